// File: rtl/gf_adder_top.sv
`default_nettype none
// ============================================================================
// Module   : gf_adder_top
// Brief    : Registered adder that returns either GF(2) addition (a XOR b)
//            or full-width unsigned addition with carry-out, 1-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module gf_adder_top #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             gf_option,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             out_valid_q, out_valid_d;

  // One extra bit keeps the carry exact even for all-ones operands.
  logic [WIDTH:0]   w_int_sum;

  assign w_int_sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    sum_d       = sum_q;
    co_d        = co_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      if (gf_option) begin
        sum_d = a ^ b;
        co_d  = 1'b0;
      end else begin
        sum_d = w_int_sum[WIDTH-1:0];
        co_d  = w_int_sum[WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      co_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      co_q        <= co_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign co        = co_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_gf_adder_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf_adder_top
// Brief    : Scoreboard bench for gf_adder_top: driver queues expected
//            results, a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf_adder_top;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             gf_option = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             out_valid;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             co;
    string            name;
  } exp_t;

  exp_t             sb_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [WIDTH-1:0] last_sum = '0;
  logic             last_co  = 1'b0;

  gf_adder_top #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .gf_option (gf_option),
    .a         (a),
    .b         (b),
    .sum       (sum),
    .co        (co),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: checks reset values, held values and queued results on negedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_sum", {1'b0, sum}, '0);
      chk("reset_co", {{WIDTH{1'b0}}, co}, '0);
      chk("reset_out_valid", {{WIDTH{1'b0}}, out_valid}, '0);
      last_sum = '0;
      last_co  = 1'b0;
      sb_q.delete();
    end else if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_valid: got out_valid=1, expected 0 (no pending op)");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_sum"}, {1'b0, sum}, {1'b0, e.sum});
        chk({e.name, "_co"}, {{WIDTH{1'b0}}, co}, {{WIDTH{1'b0}}, e.co});
        last_sum = e.sum;
        last_co  = e.co;
      end
    end else begin
      chk("hold_sum", {1'b0, sum}, {1'b0, last_sum});
      chk("hold_co", {{WIDTH{1'b0}}, co}, {{WIDTH{1'b0}}, last_co});
    end
  end

  // Drive one cycle of inputs just after posedge; queue the expectation if valid.
  task automatic issue(input logic v, input logic g, input logic [WIDTH-1:0] ai,
                       input logic [WIDTH-1:0] bi, input logic [WIDTH-1:0] es,
                       input logic ec, input string name);
    exp_t e;
    in_valid  = v;
    gf_option = g;
    a         = ai;
    b         = bi;
    if (v) begin
      e.sum  = es;
      e.co   = ec;
      e.name = name;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH:0]   ref_sum;
    logic [WIDTH-1:0] ra, rb;
    logic             rv, rg;

    // Reset held with valid random traffic for 3 cycles.
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      gf_option = 1'($urandom_range(0, 1));
      a         = $urandom;
      b         = $urandom;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;

    issue(1'b1, 1'b1, 32'd10, 32'd25, 32'd19, 1'b0, "gf_10_25");
    issue(1'b1, 1'b1, 32'd28, 32'd72, 32'd84, 1'b0, "gf_28_72");
    issue(1'b1, 1'b0, 32'd10, 32'd25, 32'd35, 1'b0, "int_10_25");
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, "int_wrap");
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, "int_all_ones");
    issue(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0, "switch_gf");
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, "switch_int");
    issue(1'b1, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, "int_no_carry");

    // Hold: a nonzero result, then two idle cycles with changing operands.
    issue(1'b1, 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, "pre_hold");
    issue(1'b0, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, '0, 1'b0, "idle0");
    issue(1'b0, 1'b1, 32'hCAFE_F00D, 32'h0000_0001, '0, 1'b0, "idle1");

    // Reset between edges with a valid op presented: outputs clear at once.
    in_valid  = 1'b1;
    gf_option = 1'b0;
    a         = 32'h0000_0005;
    b         = 32'h0000_0007;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_sum", {1'b0, sum}, '0);
    chk("async_reset_co", {{WIDTH{1'b0}}, co}, '0);
    chk("async_reset_out_valid", {{WIDTH{1'b0}}, out_valid}, '0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(1'b0, 1'b0, 32'd3, 32'd4, '0, 1'b0, "post_reset_idle");
    issue(1'b1, 1'b0, 32'd3, 32'd4, 32'd7, 1'b0, "post_reset_first");
    issue(1'b1, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, "post_reset_gf");

    // Random traffic against a plain arithmetic reference.
    for (int i = 0; i < 10000; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rg = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
      rb = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
      ref_sum = rg ? {1'b0, ra ^ rb} : ({1'b0, ra} + {1'b0, rb});
      issue(rv, rg, ra, rb, ref_sum[WIDTH-1:0], ref_sum[WIDTH], "rand");
    end

    issue(1'b0, 1'b0, '0, '0, '0, 1'b0, "drain");
    @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending results, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
